// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: two-stage valid/ready AES SubBytes engine.
// Stage 1 registers the incoming beat. Stage 2 registers the per-lane
// forward or inverse S-box result. Both S-boxes come from one GF(2^8)
// inversion per lane, wrapped in the forward or inverse affine map.
module sub_bytes_pipe #(
    parameter int LANES = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_inv,
    output logic [31:0]          beat_cnt
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    endfunction

    // Forward: affine(inv(b)). Inverse: inv(affine^-1(b)). The inversion is shared.
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [7:0] pre;
        logic [7:0] g;
        pre = inv ? affine_inv(b) : b;
        g   = gf_inv(pre);
        return inv ? g : affine_fwd(g);
    endfunction

    logic                v1;
    logic                v2;
    logic [8*LANES-1:0]  s1_data;
    logic                s1_inv;
    logic [TAG_W-1:0]    s1_tag;
    logic [8*LANES-1:0]  sub_data;
    logic                adv1;
    logic                adv2;
    logic                accept;
    logic                deliver;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1 && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign deliver   = v2 && out_ready && !flush;
    assign out_valid = v2;

    // Per-lane substitution of the stage-1 beat
    always_comb begin
        sub_data = '0;
        for (int k = 0; k < LANES; k++) begin
            sub_data[8*k +: 8] = sub_byte(s1_data[8*k +: 8], s1_inv);
        end
    end

    // Stage 1: capture accepted input beats; flush only drops the valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_data <= '0;
            s1_inv  <= 1'b0;
            s1_tag  <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_inv  <= in_inv;
                s1_tag  <= in_tag;
            end
        end
    end

    // Stage 2: register the substituted beat; holds while stalled downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_inv  <= 1'b0;
            out_tag  <= '0;
        end else if (flush) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_data <= sub_data;
                out_inv  <= s1_inv;
                out_tag  <= s1_tag;
            end
        end
    end

    // Delivered-beat counter; survives flush, wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 32'd0;
        end else if (deliver) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

endmodule
